// File: rtl/bank_arb.sv
// bank_arb -- two-port arbiter in front of a single memory bank controller.
//
// Purpose:
//   Accepts one read or write request at a time from two requesters, issues
//   a one-cycle w_en/r_en pulse to bank_ctrl, and returns a one-cycle
//   completion pulse to the owning port.
//   The state sequence tracks bank_ctrl: IDLE=PRE, WR=WRITE, RD1=SENSE1,
//   RD2=SENSE2.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   reqN_vld/we/addr/wdata       request from port N (N = 0,1)
//   reqN_rdy                     combinational grant; handshake = vld & rdy
//   w_en, r_en                   one-cycle bank command pulses
//   bank_addr, bank_wdata        address/data latched at acceptance
//   bank_rdata                   sense-amp data, sampled at the end of RD2
//   rspN_vld                     one-cycle completion pulse for port N
//   rsp_we                       completed op was a write (valid with rspN_vld)
//   rsp_rdata                    data of the most recent completed read
//
// Configuration:
//   BANK_ARB_FIXPRI_EN  defined   -> fixed priority, port 0 wins contention
//                       undefined -> round-robin, port 0 wins first contention
//
// State table:
//   IDLE | bank precharged, requests may be granted
//   WR   | write pulse on w_en
//   RD1  | first sense cycle, read pulse on r_en
//   RD2  | second sense cycle, bank_rdata valid at the closing edge

module bank_arb (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_vld,
  input  logic        req0_we,
  input  logic [5:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_rdy,

  input  logic        req1_vld,
  input  logic        req1_we,
  input  logic [5:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_rdy,

  output logic        w_en,
  output logic        r_en,
  output logic [5:0]  bank_addr,
  output logic [15:0] bank_wdata,
  input  logic [15:0] bank_rdata,

  output logic        rsp0_vld,
  output logic        rsp1_vld,
  output logic        rsp_we,
  output logic [15:0] rsp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        gnt_vld;
  logic        gnt_port;
  logic        accept;
  logic        sel_we;
  logic [5:0]  sel_addr;
  logic [15:0] sel_wdata;

  logic        op_port_q;
  logic        op_done;

`ifndef BANK_ARB_FIXPRI_EN
  // Port granted most recently; reset to 1 so port 0 wins the first contention.
  logic        last_port_q;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_vld  = req0_vld | req1_vld;
    gnt_port = 1'b0;
`ifdef BANK_ARB_FIXPRI_EN
    gnt_port = ~req0_vld;
`else
    if (req0_vld && req1_vld) begin
      gnt_port = ~last_port_q;
    end else begin
      gnt_port = req1_vld;
    end
`endif
  end

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign req0_rdy = accept && !gnt_port;
  assign req1_rdy = accept &&  gnt_port;

  always_comb begin
    sel_we    = req0_we;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (gnt_port) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = sel_we ? WR : RD1;
        end
      end
      WR:      state_d = IDLE;
      RD1:     state_d = RD2;
      RD2:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // WR and RD2 are the last cycles of their operations.
  assign op_done = (state_q == WR) || (state_q == RD2);

  // ---------------------------------------------------------------------------
  // Registered outputs and operation context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en       <= 1'b0;
      r_en       <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      op_port_q  <= 1'b0;
      rsp0_vld   <= 1'b0;
      rsp1_vld   <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      // Pulses follow the next state so they line up with WR / RD1 exactly.
      w_en     <= (state_d == WR);
      r_en     <= (state_d == RD1);

      rsp0_vld <= op_done && !op_port_q;
      rsp1_vld <= op_done &&  op_port_q;

      if (accept) begin
        bank_addr  <= sel_addr;
        bank_wdata <= sel_wdata;
        op_port_q  <= gnt_port;
      end

      if (op_done) begin
        rsp_we <= (state_q == WR);
      end

      if (state_q == RD2) begin
        rsp_rdata <= bank_rdata;
      end
    end
  end

`ifndef BANK_ARB_FIXPRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_port_q <= 1'b1;
    end else if (accept) begin
      last_port_q <= gnt_port;
    end
  end
`endif

endmodule

// File: tb/tb_bank_arb.sv
module tb_bank_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_vld, req0_we, req0_rdy;
  logic [5:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_vld, req1_we, req1_rdy;
  logic [5:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        w_en, r_en;
  logic [5:0]  bank_addr;
  logic [15:0] bank_wdata;
  logic [15:0] bank_rdata;
  logic        rsp0_vld, rsp1_vld, rsp_we;
  logic [15:0] rsp_rdata;

  int n_chk;
  int n_err;

  bank_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_vld   (req0_vld),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_rdy   (req0_rdy),
    .req1_vld   (req1_vld),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_rdy   (req1_rdy),
    .w_en       (w_en),
    .r_en       (r_en),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata),
    .rsp0_vld   (rsp0_vld),
    .rsp1_vld   (rsp1_vld),
    .rsp_we     (rsp_we),
    .rsp_rdata  (rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command pulses must never overlap.
  always @(negedge clk) begin
    if (rst_n) chk("we_re_overlap", {31'd0, w_en & r_en}, 32'd0);
  end

  logic exp_port;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0_vld = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_vld = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    bank_rdata = '0;

    tick();
    tick();
    chk("rst_w_en", w_en, 0);
    chk("rst_r_en", r_en, 0);
    chk("rst_bank_addr", bank_addr, 0);
    chk("rst_bank_wdata", bank_wdata, 0);
    chk("rst_rsp0", rsp0_vld, 0);
    chk("rst_rsp1", rsp1_vld, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single write on port 0
    req0_vld = 1; req0_we = 1; req0_addr = 6'h05; req0_wdata = 16'hA5A5;
    #1;
    chk("wr_rdy0", req0_rdy, 1);
    chk("wr_rdy1", req1_rdy, 0);
    tick();                                  // accept edge
    req0_vld = 0;
    chk("wr_w_en", w_en, 1);
    chk("wr_r_en", r_en, 0);
    chk("wr_addr", bank_addr, 6'h05);
    chk("wr_wdata", bank_wdata, 16'hA5A5);
    chk("wr_rsp0_early", rsp0_vld, 0);
    chk("wr_busy_rdy0", req0_rdy, 0);
    tick();
    chk("wr_rsp0", rsp0_vld, 1);
    chk("wr_rsp1", rsp1_vld, 0);
    chk("wr_rsp_we", rsp_we, 1);
    chk("wr_w_en_off", w_en, 0);
    tick();
    chk("wr_rsp0_pulse", rsp0_vld, 0);
    chk("wr_addr_hold", bank_addr, 6'h05);

    // Single read on port 1
    req1_vld = 1; req1_we = 0; req1_addr = 6'h3F; req1_wdata = 16'h0000;
    #1;
    chk("rd_rdy1", req1_rdy, 1);
    chk("rd_rdy0", req0_rdy, 0);
    tick();
    req1_vld = 0;
    chk("rd_r_en", r_en, 1);
    chk("rd_w_en", w_en, 0);
    chk("rd_addr", bank_addr, 6'h3F);
    tick();                                  // RD2
    bank_rdata = 16'h1234;
    chk("rd_r_en_off", r_en, 0);
    chk("rd_rsp1_early", rsp1_vld, 0);
    tick();
    bank_rdata = 16'hFFFF;
    chk("rd_rsp1", rsp1_vld, 1);
    chk("rd_rsp0", rsp0_vld, 0);
    chk("rd_rsp_we", rsp_we, 0);
    chk("rd_rdata", rsp_rdata, 16'h1234);
    tick();
    chk("rd_rsp1_pulse", rsp1_vld, 0);
    chk("rd_rdata_hold", rsp_rdata, 16'h1234);

    // Contention: both ports issue writes continuously
    req0_vld = 1; req0_we = 1; req0_addr = 6'h0A; req0_wdata = 16'h1111;
    req1_vld = 1; req1_we = 1; req1_addr = 6'h2B; req1_wdata = 16'h2222;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef BANK_ARB_FIXPRI_EN
      exp_port = 1'b0;
`else
      exp_port = i[0];
`endif
      chk($sformatf("cont%0d_rdy0", i), req0_rdy, !exp_port);
      chk($sformatf("cont%0d_rdy1", i), req1_rdy, exp_port);
      tick();
      chk($sformatf("cont%0d_w_en", i), w_en, 1);
      chk($sformatf("cont%0d_addr", i), bank_addr, exp_port ? 6'h2B : 6'h0A);
      chk($sformatf("cont%0d_wdata", i), bank_wdata, exp_port ? 16'h2222 : 16'h1111);
      tick();
      chk($sformatf("cont%0d_rsp0", i), rsp0_vld, !exp_port);
      chk($sformatf("cont%0d_rsp1", i), rsp1_vld, exp_port);
    end
    req0_vld = 0; req1_vld = 0;
    tick();
    chk("cont_idle_w_en", w_en, 0);
    chk("cont_rdata_kept", rsp_rdata, 16'h1234);

    // Back-to-back write then read on port 0, plus a dropped port-1 request
    req0_vld = 1; req0_we = 1; req0_addr = 6'h10; req0_wdata = 16'hC3C3;
    tick();                                  // write accepted
    req0_we = 0; req0_addr = 6'h11;
    #1;
    chk("b2b_busy_rdy0", req0_rdy, 0);
    tick();                                  // rsp cycle of the write
    chk("b2b_wr_rsp0", rsp0_vld, 1);
    chk("b2b_wr_rsp_we", rsp_we, 1);
    chk("b2b_rdy0", req0_rdy, 1);
    tick();                                  // read accepted
    req0_vld = 0;
    req1_vld = 1; req1_we = 1; req1_addr = 6'h22; req1_wdata = 16'h5555;
    bank_rdata = 16'hBEEF;
    chk("b2b_r_en", r_en, 1);
    chk("b2b_w_en", w_en, 0);
    chk("b2b_addr", bank_addr, 6'h11);
    tick();                                  // RD2
    req1_vld = 0;
    tick();
    chk("b2b_rd_rsp0", rsp0_vld, 1);
    chk("b2b_rd_rsp_we", rsp_we, 0);
    chk("b2b_rdata", rsp_rdata, 16'hBEEF);
    tick();
    chk("drop_w_en", w_en, 0);
    chk("drop_r_en", r_en, 0);
    chk("drop_addr", bank_addr, 6'h11);

    // Reset during RD1
    req1_vld = 1; req1_we = 0; req1_addr = 6'h07;
    #1;
    chk("rstop_rdy1", req1_rdy, 1);
    tick();
    req1_vld = 0;
    chk("rstop_r_en", r_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rstop_r_en_clr", r_en, 0);
    chk("rstop_w_en_clr", w_en, 0);
    chk("rstop_addr_clr", bank_addr, 0);
    chk("rstop_wdata_clr", bank_wdata, 0);
    chk("rstop_rdata_clr", rsp_rdata, 0);
    chk("rstop_rsp_we_clr", rsp_we, 0);
    tick();
    tick();
    chk("rstop_rsp1_held", rsp1_vld, 0);
    rst_n = 1'b1;
    tick();
    chk("rstop_rsp1_after", rsp1_vld, 0);
    chk("rstop_r_en_after", r_en, 0);
    req0_vld = 1; req0_we = 1; req0_addr = 6'h01; req0_wdata = 16'h0F0F;
    req1_vld = 1; req1_we = 1; req1_addr = 6'h02; req1_wdata = 16'hF0F0;
    #1;
    chk("rstop_first_rdy0", req0_rdy, 1);
    chk("rstop_first_rdy1", req1_rdy, 0);
    tick();
    req0_vld = 0; req1_vld = 0;
    chk("rstop_first_w_en", w_en, 1);
    chk("rstop_first_addr", bank_addr, 6'h01);
    tick();
    chk("rstop_first_rsp0", rsp0_vld, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bank_arb.md
BANK_ARB -- requirements
Module: bank_arb

Interface
REQ-001 SHALL have ports: clk  input  1  bank clock, rising-edge; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have per-port request inputs, N in {0,1}: reqN_vld  input  1  request valid; reqN_we  input  1  1=write, 0=read; reqN_addr  input  6  row address; reqN_wdata  input  16  write data.
REQ-003 SHALL have reqN_rdy  output  1  request accepted this cycle.
REQ-004 SHALL have bank-side ports: w_en  output  1  write pulse to bank_ctrl; r_en  output  1  read pulse to bank_ctrl; bank_addr  output  6  latched address; bank_wdata  output  16  latched write data; bank_rdata  input  16  sense-amp data.
REQ-005 SHALL have response ports: rspN_vld  output  1  completion pulse for port N; rsp_we  output  1  completed op was a write; rsp_rdata  output  16  read data.

Function
REQ-006 SHALL implement FSM states IDLE, WR, RD1, RD2, matching bank_ctrl PRE/WRITE/SENSE1/SENSE2.
REQ-007 SHALL accept a request only in IDLE; handshake completes when reqN_vld and reqN_rdy are both 1 on a clock edge.
REQ-008 reqN_rdy SHALL be combinational: 1 only in IDLE, and only for the single granted port; it SHALL be 0 for both ports outside IDLE.
REQ-009 Arbitration SHALL be round-robin: on contention, grant the port not granted last; with a single valid request, grant it.
REQ-010 On acceptance, SHALL latch addr/wdata/we/port into bank_addr/bank_wdata/internal regs and assert w_en (write) or r_en (read) for exactly one cycle, the cycle after acceptance.
REQ-011 Transitions: IDLE->WR on accepted write; IDLE->RD1 on accepted read; WR->IDLE; RD1->RD2; RD2->IDLE; IDLE->IDLE otherwise.
REQ-012 w_en SHALL equal state==WR registered-out, and r_en SHALL be 1 only in the RD1 cycle; w_en and r_en SHALL never both be 1.
REQ-013 In RD2, SHALL capture bank_rdata into rsp_rdata at the RD2->IDLE edge.
REQ-014 rspN_vld SHALL pulse for one cycle, for the owning port only: in the cycle after WR (write), or in the cycle after RD2 (read); rsp_we SHALL be valid with it.
REQ-015 Latency from accept edge to rsp_vld: write 2 cycles, read 3 cycles.
REQ-016 A new request SHALL be acceptable in the same cycle rspN_vld is high (back-to-back, no bubble beyond IDLE).
REQ-017 bank_addr/bank_wdata SHALL hold stable from the w_en/r_en cycle until the next acceptance.
REQ-018 rsp_rdata SHALL hold its value until the next read completes; writes SHALL not modify it.
REQ-019 Requests with vld deasserted before acceptance SHALL be dropped without side effects; no queueing.

Reset
REQ-020 On rst_n low, state SHALL go to IDLE asynchronously; w_en, r_en, rspN_vld, rsp_we, bank_addr, bank_wdata, rsp_rdata SHALL be 0.
REQ-021 Round-robin pointer SHALL reset so that port 0 wins the first contention.
REQ-022 Reset mid-operation SHALL abort the op with no rsp_vld pulse; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-023 Macro BANK_ARB_FIXPRI_EN defined: fixed priority, port 0 always wins contention, and the pointer is unused; undefined: round-robin per REQ-009.

Verification
REQ-024 Single write port0 addr=0x05 data=0xA5A5 -> w_en one cycle after accept, bank_addr=0x05, rsp0_vld 2 cycles after accept, rsp_we=1.
REQ-025 Single read port1 addr=0x3F, bank_rdata=0x1234 during RD2 -> r_en one cycle, rsp1_vld 3 cycles after accept, rsp_rdata=0x1234, rsp_we=0.
REQ-026 Both ports valid continuously, 4 ops -> grants 0,1,0,1 (round-robin); with BANK_ARB_FIXPRI_EN -> 0,0,0,0.
REQ-027 Write then read back-to-back on port0 -> read accepted in the rsp cycle of the write; w_en/r_en never overlap.
REQ-028 rst_n low during RD1 -> all outputs 0 immediately, no rsp_vld, port0 granted first after release.
